// File: rtl/key_schedule_ctrl_if.sv
// Host, external S-box and round-key storage signals of the AES-128 key schedule controller.
// The controller connects through the slave modport; the host/storage side uses master.
interface key_schedule_ctrl_if;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic         WR_EN;
    logic [3:0]   index;
    logic [1:0]   blk_no;
    logic [31:0]  word;

    modport master (
        output start, cipher_key, sbox_out,
        input  busy, done, keys_valid, sbox_in, WR_EN, index, blk_no, word
    );

    modport slave (
        input  start, cipher_key, sbox_out,
        output busy, done, keys_valid, sbox_in, WR_EN, index, blk_no, word
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion: writes round keys 1..10 (one word per cycle), done pulse 41 cycles after start.
// No backpressure: storage must accept every write; start is ignored while busy.
module key_schedule_ctrl (
    input  logic              clk,
    input  logic              reset_n,
    key_schedule_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [3:0][31:0]  w;
    logic [3:0]        r;
    logic [1:0]        j;
    logic [31:0]       t;
    logic [31:0]       nxt_word;
    logic              busy_q;
    logic              done_q;
    logic              kv_q;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // S-box lookup is combinational outside the block, so the written word is too.
    assign bus.sbox_in = {w[3][23:0], w[3][31:24]};
    assign t           = (j == 2'd0) ? (bus.sbox_out ^ {rcon(r), 24'h0}) : w[3];
    assign nxt_word    = w[0] ^ t;

    assign bus.WR_EN      = (state == RUN);
    assign bus.index      = (state == RUN) ? r        : 4'd0;
    assign bus.blk_no     = (state == RUN) ? j        : 2'd0;
    assign bus.word       = (state == RUN) ? nxt_word : 32'd0;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = kv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            w      <= '0;
            r      <= 4'd1;
            j      <= 2'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            kv_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        w[0]   <= bus.cipher_key[127:96];
                        w[1]   <= bus.cipher_key[95:64];
                        w[2]   <= bus.cipher_key[63:32];
                        w[3]   <= bus.cipher_key[31:0];
                        r      <= 4'd1;
                        j      <= 2'd0;
                        kv_q   <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    w[0] <= w[1];
                    w[1] <= w[2];
                    w[2] <= w[3];
                    w[3] <= nxt_word;
                    j    <= j + 2'd1;
                    if (j == 2'd3) begin
                        if (r == 4'd10) begin
                            r      <= 4'd1;
                            done_q <= 1'b1;
                            kv_q   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            r <= r + 4'd1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: FIPS-197 reference expansion model with a computed AES S-box.
module tb_key_schedule_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  sb [256];
    logic [31:0] exp_w [44];
    logic [31:0] got_w [40];

    key_schedule_ctrl_if bus ();

    key_schedule_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.sbox_out = {sb[bus.sbox_in[31:24]], sb[bus.sbox_in[23:16]],
                           sb[bus.sbox_in[15:8]],  sb[bus.sbox_in[7:0]]};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    // Textbook key expansion: all 44 words, Rcon by repeated doubling in GF(2^8).
    task automatic model(input logic [127:0] key);
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) exp_w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = exp_w[i-1];
            if (i % 4 == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            exp_w[i] = exp_w[i-4] ^ tmp;
        end
    endtask

    // Entered and left at a falling edge with the DUT idle; abort_at>0 pulses reset in that write cycle.
    task automatic expand(input logic [127:0] key, input bit hold, input int abort_at);
        int nwr = 0;
        model(key);
        bus.start      = 1'b1;
        bus.cipher_key = key;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        for (int cyc = 1; cyc <= 41; cyc++) begin
            if (cyc == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk("abort_wr", {bus.WR_EN, bus.index, bus.blk_no, bus.word}, 64'd0);
                chk("abort_flags", {bus.busy, bus.done, bus.keys_valid}, 64'd0);
                bus.start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_quiet", {bus.WR_EN, bus.busy, bus.keys_valid}, 64'd0);
                end
                reset_n = 1'b1;
                return;
            end
            if (cyc <= 40) begin
                chk("wr", {bus.WR_EN, bus.index, bus.blk_no, bus.word},
                    {1'b1, 4'((cyc - 1) / 4 + 1), 2'((cyc - 1) % 4), exp_w[cyc + 3]});
                chk("flags_run", {bus.busy, bus.done, bus.keys_valid}, 64'b100);
                got_w[cyc - 1] = bus.word;
            end else begin
                chk("done_wr", {bus.WR_EN, bus.index, bus.blk_no, bus.word}, 64'd0);
                chk("flags_done", {bus.busy, bus.done, bus.keys_valid}, 64'b111);
            end
            if (bus.WR_EN) nwr++;
            @(negedge clk);
        end
        chk("nwr", 64'(nwr), 64'd40);
        chk("idle_flags", {bus.busy, bus.done, bus.keys_valid, bus.WR_EN}, 64'b0010);
        chk("idle_sbox_in", bus.sbox_in, {exp_w[43][23:0], exp_w[43][31:24]});
    endtask

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) begin
            chk("kv_hold", {bus.keys_valid, bus.busy, bus.WR_EN}, 64'b100);
            @(negedge clk);
        end
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        logic [127:0] k;
        bus.start      = 1'b0;
        bus.cipher_key = '0;
        build_sbox();
        repeat (2) @(negedge clk);
        chk("rst_wr", {bus.WR_EN, bus.index, bus.blk_no, bus.word}, 64'd0);
        chk("rst_flags", {bus.busy, bus.done, bus.keys_valid}, 64'd0);
        chk("rst_sbox_in", bus.sbox_in, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        expand(FIPS_KEY, 1'b0, 0);
        chk("fips_r1w0", got_w[0], 32'ha0fafe17);
        chk("fips_r1w1", got_w[1], 32'h88542cb1);
        chk("fips_r1w2", got_w[2], 32'h23a33939);
        chk("fips_r1w3", got_w[3], 32'h2a6c7605);
        chk("fips_r10w0", got_w[36], 32'hd014f9a8);
        chk("fips_r10w1", got_w[37], 32'hc9ee2589);
        chk("fips_r10w2", got_w[38], 32'he13f0cc8);
        chk("fips_r10w3", got_w[39], 32'hb6630ca6);
        idle_gap(3);

        expand(128'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk("zero_r1", got_w[i], 32'h62636363);

        // start held high across back-to-back expansions
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k, 1'b1, 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k, 1'b1, 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k, 1'b0, 0);
        idle_gap(2);

        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k, 1'b0, 17);
        chk("post_abort", {bus.keys_valid, bus.busy, bus.WR_EN}, 64'd0);
        expand(FIPS_KEY, 1'b0, 0);
        chk("post_abort_r10w3", got_w[39], 32'hb6630ca6);

        for (int n = 0; n < 4; n++) begin
            idle_gap($urandom_range(0, 3));
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
